// File: rtl/square_motion_engine.sv
// Once-per-frame position update for up to five bouncing squares.
// A synchronous vsync rising edge starts a sweep that updates one object per clock.
module square_motion_engine #(
  parameter int unsigned NUM_OBJ  = 5,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic                   enable,
  input  logic [7:0]             size,
  output logic [10*NUM_OBJ-1:0]  x_pos,
  output logic [10*NUM_OBJ-1:0]  y_pos,
  output logic                   busy,
  output logic                   frame_tick
);

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e      r_state, w_state_next;
  logic        r_vsync_d;
  logic [2:0]  r_idx;
  logic [7:0]  r_size_q;
  logic        r_busy, r_tick;
  logic [9:0]  r_x [NUM_OBJ];
  logic [9:0]  r_y [NUM_OBJ];
  logic        r_dir_x [NUM_OBJ];
  logic        r_dir_y [NUM_OBJ];

  logic        w_vsync_rise, w_last;
  logic [7:0]  w_size_clamp;
  logic [10:0] w_lim_x, w_lim_y, w_idx11;
  logic [9:0]  w_x_cur, w_y_cur;
  logic        w_dx_cur, w_dy_cur;
  logic [10:0] w_x_res, w_y_res;

  function automatic logic [9:0] rst_x(input int unsigned i);
    case (i)
      0:       rst_x = 10'd0;
      1:       rst_x = 10'd120;
      2:       rst_x = 10'd100;
      3:       rst_x = 10'd40;
      default: rst_x = 10'd40;
    endcase
  endfunction

  function automatic logic [9:0] rst_y(input int unsigned i);
    case (i)
      0:       rst_y = 10'd300;
      1:       rst_y = 10'd300;
      2:       rst_y = 10'd400;
      3:       rst_y = 10'd200;
      default: rst_y = 10'd50;
    endcase
  endfunction

  // Returns {dir, pos}; the position never leaves [0, lim].
  function automatic logic [10:0] axis_step(input logic [9:0]  pos,
                                            input logic        dir,
                                            input logic [10:0] lim,
                                            input logic [10:0] fwd,
                                            input logic [10:0] back);
    logic [10:0] n;
    if (dir) begin
      n = {1'b0, pos} + fwd;
      if (n >= lim) axis_step = {1'b0, lim[9:0]};
      else          axis_step = {1'b1, n[9:0]};
    end else if ({1'b0, pos} <= back) begin
      axis_step = {1'b1, 10'd0};
    end else begin
      n = {1'b0, pos} - back;
      if (n > lim) n = lim;
      axis_step = {1'b0, n[9:0]};
    end
  endfunction

  assign w_vsync_rise = vsync & ~r_vsync_d;
  assign w_last       = (r_idx == 3'(NUM_OBJ - 1));
  assign w_size_clamp = (size < 8'd8) ? 8'd8 : ((size > 8'd240) ? 8'd240 : size);
  assign w_lim_x      = 11'(H_ACTIVE) - {3'b000, r_size_q};
  assign w_lim_y      = 11'(V_ACTIVE) - {3'b000, r_size_q};
  assign w_idx11      = {8'd0, r_idx};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_vsync_rise && enable) w_state_next = StSweep;
      StSweep: if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_x_cur  = '0;
    w_y_cur  = '0;
    w_dx_cur = 1'b0;
    w_dy_cur = 1'b0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      if (r_idx == 3'(i)) begin
        w_x_cur  = r_x[i];
        w_y_cur  = r_y[i];
        w_dx_cur = r_dir_x[i];
        w_dy_cur = r_dir_y[i];
      end
    end
    w_x_res = axis_step(w_x_cur, w_dx_cur, w_lim_x, 11'd7 + w_idx11, 11'd3 + w_idx11);
    w_y_res = axis_step(w_y_cur, w_dy_cur, w_lim_y, 11'd6 + w_idx11, 11'd10 + w_idx11);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_vsync_d <= 1'b0;
      r_idx     <= '0;
      r_size_q  <= 8'd80;
      r_busy    <= 1'b0;
      r_tick    <= 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        r_x[i]     <= rst_x(i);
        r_y[i]     <= rst_y(i);
        r_dir_x[i] <= (i == 1) || (i == 2) || (i == 3);
        r_dir_y[i] <= (i != 1);
      end
    end else begin
      r_vsync_d <= vsync;
      r_state   <= w_state_next;
      r_busy    <= (w_state_next != StIdle);
      r_tick    <= (w_state_next == StDone);
      if (r_state == StIdle && w_state_next == StSweep) begin
        r_idx    <= '0;
        r_size_q <= w_size_clamp;
      end
      if (r_state == StSweep) begin
        for (int i = 0; i < NUM_OBJ; i++) begin
          if (r_idx == 3'(i)) begin
            r_x[i]     <= w_x_res[9:0];
            r_dir_x[i] <= w_x_res[10];
            r_y[i]     <= w_y_res[9:0];
            r_dir_y[i] <= w_y_res[10];
          end
        end
        r_idx <= r_idx + 3'd1;
      end
    end
  end

  always_comb begin
    x_pos = '0;
    y_pos = '0;
    for (int i = 0; i < NUM_OBJ; i++) begin
      x_pos[10*i +: 10] = r_x[i];
      y_pos[10*i +: 10] = r_y[i];
    end
  end

  assign busy       = r_busy;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_square_motion_engine.sv
// Directed bench for square_motion_engine: sweep timing, bounce arithmetic,
// enable gating, size clamping and mid-sweep reset.
module tb_square_motion_engine;

  logic        clk = 1'b0;
  logic        reset, vsync, enable;
  logic [7:0]  size;
  logic [49:0] x_pos, y_pos;
  logic        busy, frame_tick;

  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] ex [5];
  logic [9:0] ey [5];

  square_motion_engine #(.NUM_OBJ(5), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .enable     (enable),
    .size       (size),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .busy       (busy),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pos(input string tag);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("%s x%0d", tag, i), 32'(x_pos[10*i +: 10]), 32'(ex[i]));
      check($sformatf("%s y%0d", tag, i), 32'(y_pos[10*i +: 10]), 32'(ey[i]));
    end
  endtask

  // Cycle E is the cycle vsync first reads high; expects busy E+1..E+6, tick only at E+6.
  // With toggle set, vsync is pulsed low and high again inside the sweep.
  task automatic sweep(input string tag, input bit toggle);
    vsync = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (toggle && k == 2) vsync = 1'b0;
      if (toggle && k == 3) vsync = 1'b1;
      check($sformatf("%s busy@E+%0d", tag, k), 32'(busy), 32'(k <= 6));
      check($sformatf("%s tick@E+%0d", tag, k), 32'(frame_tick), 32'(k == 6));
    end
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    reset  = 1'b1;
    vsync  = 1'b0;
    enable = 1'b1;
    size   = 8'd80;
    #2;
    ex = '{10'd0, 10'd120, 10'd100, 10'd40, 10'd40};
    ey = '{10'd300, 10'd300, 10'd400, 10'd200, 10'd50};
    check_pos("reset");
    check("reset busy", 32'(busy), 32'd0);
    check("reset tick", 32'(frame_tick), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("idle tick", 32'(frame_tick), 32'd0);

    sweep("sweep1", 1'b0);
    ex = '{10'd0, 10'd128, 10'd109, 10'd50, 10'd33};
    ey = '{10'd306, 10'd289, 10'd400, 10'd209, 10'd60};
    check_pos("sweep1");

    // Second sweep also checks that a vsync re-edge inside SWEEP is not queued.
    sweep("sweep2", 1'b1);
    ex = '{10'd7, 10'd136, 10'd118, 10'd60, 10'd26};
    ey = '{10'd312, 10'd278, 10'd388, 10'd218, 10'd70};
    check_pos("sweep2");

    enable = 1'b0;
    for (int e = 0; e < 3; e++) begin
      vsync = 1'b1;
      for (int k = 0; k < 4; k++) begin
        tick();
        check("disabled tick", 32'(frame_tick), 32'd0);
        check("disabled busy", 32'(busy), 32'd0);
      end
      vsync = 1'b0;
      tick();
    end
    check_pos("disabled");
    enable = 1'b1;

    size = 8'd250;
    sweep("clamp", 1'b0);
    ex = '{10'd14, 10'd144, 10'd127, 10'd70, 10'd19};
    ey = '{10'd240, 10'd240, 10'd240, 10'd227, 10'd80};
    check_pos("clamp");
    size = 8'd80;

    // Reset during cycle E+3 of a sweep.
    vsync = 1'b1;
    tick();
    tick();
    tick();
    check("pre-reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    ex = '{10'd0, 10'd120, 10'd100, 10'd40, 10'd40};
    ey = '{10'd300, 10'd300, 10'd400, 10'd200, 10'd50};
    check_pos("midreset");
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset tick", 32'(frame_tick), 32'd0);
    vsync = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("post-reset tick", 32'(frame_tick), 32'd0);
      check("post-reset busy", 32'(busy), 32'd0);
    end
    check_pos("post-reset");

    sweep("resweep", 1'b0);
    check("resweep x0", 32'(x_pos[9:0]), 32'd0);
    check("resweep y0", 32'(y_pos[9:0]), 32'd306);
    check("resweep x4", 32'(x_pos[49:40]), 32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
